// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial receiver with mid-bit sampling and a small receive FIFO.
// Bytes are assembled LSB first. Each complete byte is pushed into a FIFO_DEPTH-entry queue.
// Framing errors and FIFO overruns are reported through sticky flags.
// Optional feature macro: UART_RX_PARITY_EN. When defined, the frame is 8E1 and a PARITY
// state checks even parity. When undefined, the frame is plain 8N1.
// Pop handshake: the head byte on o_data is valid only while o_valid=1. When o_valid and
// i_ready are both high at a posedge, that byte is consumed. i_ready is ignored while
// o_valid=0.
// o_state exposes the receive FSM state: 0 IDLE, 1 START, 2 DATA, 3 PARITY, 4 STOP.
module uart_receiver #(
    parameter int clk_divider = 48,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        rxd,
    output logic [7:0]                  o_data,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic [$clog2(FIFO_DEPTH):0] o_level,
    output logic                        o_frame_err,
    output logic                        o_overrun,
    input  logic                        i_clr_err,
    output logic [2:0]                  o_state
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = $clog2(clk_divider);
    localparam logic [TW-1:0] C_HALF     = TW'(clk_divider / 2 - 1);
    localparam logic [TW-1:0] C_FULL     = TW'(clk_divider - 1);
    localparam logic [LW-1:0] C_FULL_LVL = LW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [1:0]      r_sync;
    logic [TW-1:0]   r_timer;
    logic [2:0]      r_idx;
    logic [7:0]      r_shift;
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [LW-1:0]   r_level;
    logic            r_frame_err;
    logic            r_overrun;

    logic w_rxs, w_tick;
    logic w_load_half, w_load_full, w_clr_idx, w_shift, w_push, w_frame_set;
    logic w_par_bad;
    logic w_full, w_pop, w_wr_en, w_ovr_set;

    assign w_rxs  = r_sync[1];
    assign w_tick = (r_timer == '0);

    // Two-flop synchroniser for the asynchronous serial line; idles high out of reset.
    always_ff @(posedge clk) begin
        if (!resetn) r_sync <= 2'b11;
        else         r_sync <= {r_sync[0], rxd};
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // FSM next-state logic; STOP returns to IDLE on its tick so the next start edge is seen early.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (!w_rxs) w_next = S_START;
            S_START: if (w_tick) w_next = w_rxs ? S_IDLE : S_DATA;
            S_DATA: begin
                if (w_tick && r_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                    w_next = S_PARITY;
`else
                    w_next = S_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: if (w_tick) w_next = S_STOP;
`endif
            S_STOP:  if (w_tick) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

`ifdef UART_RX_PARITY_EN
    logic w_par_sample;
`endif

    // FSM outputs: per-state strobes that steer the timer, shifter, FIFO and flags.
    always_comb begin
        w_load_half = 1'b0;
        w_load_full = 1'b0;
        w_clr_idx   = 1'b0;
        w_shift     = 1'b0;
        w_push      = 1'b0;
        w_frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_sample = 1'b0;
`endif
        case (r_state)
            S_IDLE: w_load_half = !w_rxs;
            S_START: begin
                if (w_tick && !w_rxs) begin
                    w_load_full = 1'b1;
                    w_clr_idx   = 1'b1;
                end
            end
            S_DATA: begin
                w_shift     = w_tick;
                w_load_full = w_tick;
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                w_par_sample = w_tick;
                w_load_full  = w_tick;
            end
`endif
            S_STOP: begin
                if (w_tick) begin
                    w_push      = w_rxs && !w_par_bad;
                    w_frame_set = !w_rxs || w_par_bad;
                end
            end
            default: ;
        endcase
    end

    // Bit timer: loads half a bit after the start edge, then a full bit after each tick.
    always_ff @(posedge clk) begin
        if (!resetn)          r_timer <= '0;
        else if (w_load_half) r_timer <= C_HALF;
        else if (w_load_full) r_timer <= C_FULL;
        else if (!w_tick)     r_timer <= r_timer - 1'b1;
    end

    // Data shifter: sampled bits enter at the MSB so after eight shifts bit 0 sits at the LSB.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_shift <= '0;
            r_idx   <= '0;
        end else begin
            if (w_shift)   r_shift <= {w_rxs, r_shift[7:1]};
            if (w_clr_idx) r_idx   <= '0;
            else if (w_shift) r_idx <= r_idx + 1'b1;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic r_par_err;
    // Even-parity check: the data bits XOR the parity bit must be zero.
    always_ff @(posedge clk) begin
        if (!resetn)           r_par_err <= 1'b0;
        else if (w_clr_idx)    r_par_err <= 1'b0;
        else if (w_par_sample) r_par_err <= w_rxs ^ (^r_shift);
    end
    assign w_par_bad = r_par_err;
`else
    assign w_par_bad = 1'b0;
`endif

    assign w_full    = (r_level == C_FULL_LVL);
    assign w_pop     = o_valid && i_ready;
    assign w_wr_en   = w_push && (!w_full || w_pop);
    assign w_ovr_set = w_push && w_full && !w_pop;

    // FIFO storage write; contents are qualified by the level, so no reset is needed.
    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_ptr] <= r_shift;
    end

    // FIFO pointers and occupancy; a push and a pop in the same cycle leave the level unchanged.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr_en, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Sticky error flags; a set event in the same cycle as a clear wins.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_frame_set || (r_frame_err && !i_clr_err);
            r_overrun   <= w_ovr_set   || (r_overrun   && !i_clr_err);
        end
    end

    assign o_valid     = (r_level != '0);
    assign o_data      = o_valid ? r_mem[r_rd_ptr] : 8'h00;
    assign o_level     = r_level;
    assign o_frame_err = r_frame_err;
    assign o_overrun   = r_overrun;
    assign o_state     = r_state;
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed and randomized frames checked against a queue-based model.
module tb_uart_receiver;
    localparam int DIV   = 48;
    localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
    localparam int NPAR = 1;
`else
    localparam int NPAR = 0;
`endif
    localparam int NBITS = 10 + NPAR;
    // Cycle (counted from the start-bit drive edge) at which the stop-bit tick is taken:
    // 2 sync flops + 1 idle-detect cycle + half a bit, then one full bit per data/parity/stop bit.
    localparam int STOP_TICK = 3 + DIV / 2 + (9 + NPAR) * DIV;

    logic       clk = 1'b0;
    logic       resetn;
    logic       rxd;
    logic [7:0] o_data;
    logic       o_valid;
    logic       i_ready;
    logic [2:0] o_level;
    logic       o_frame_err;
    logic       o_overrun;
    logic       i_clr_err;
    logic [2:0] o_state;

    int checks   = 0;
    int failures = 0;

    // Reference model: the FIFO contents and the two sticky flags.
    logic [7:0] exp_q[$];
    logic       exp_ferr;
    logic       exp_ovr;

    uart_receiver #(.clk_divider(DIV), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn), .rxd(rxd), .o_data(o_data), .o_valid(o_valid),
        .i_ready(i_ready), .o_level(o_level), .o_frame_err(o_frame_err),
        .o_overrun(o_overrun), .i_clr_err(i_clr_err), .o_state(o_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_ferr = 1'b0;
        exp_ovr  = 1'b0;
    endtask

    // Frame outcome from the protocol rules: a pop at the stop tick lands first, then the byte
    // is accepted if the frame is good and room exists, otherwise it is dropped with a flag.
    task automatic model_frame(input logic [7:0] data, input logic stop_bit,
                               input logic par_bad, input bit pop_at_stop);
        if (pop_at_stop && exp_q.size() > 0) void'(exp_q.pop_front());
        if (!stop_bit || par_bad)      exp_ferr = 1'b1;
        else if (exp_q.size() < DEPTH) exp_q.push_back(data);
        else                           exp_ovr = 1'b1;
    endtask

    task automatic check_status(input string tag);
        check({tag, "_level"}, 32'(o_level), 32'(exp_q.size()));
        check({tag, "_valid"}, 32'(o_valid), 32'(exp_q.size() > 0));
        check({tag, "_ferr"},  32'(o_frame_err), 32'(exp_ferr));
        check({tag, "_ovr"},   32'(o_overrun), 32'(exp_ovr));
        if (exp_q.size() > 0) check({tag, "_head"}, 32'(o_data), 32'(exp_q[0]));
    endtask

    task automatic pop_one(input string tag);
        check({tag, "_pvalid"}, 32'(o_valid), 32'd1);
        if (exp_q.size() > 0) check({tag, "_pdata"}, 32'(o_data), 32'(exp_q[0]));
        i_ready = 1'b1;
        @(posedge clk); #1;
        i_ready = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
    endtask

    task automatic clear_err();
        i_clr_err = 1'b1;
        @(posedge clk); #1;
        i_clr_err = 1'b0;
        exp_ferr = 1'b0;
        exp_ovr  = 1'b0;
    endtask

    // Drives one frame on rxd. pop_at_stop raises i_ready for exactly the stop-tick cycle;
    // abort_at >= 0 pulses resetn low at that bit-time cycle and abandons the frame.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit, input logic par_bad,
                              input bit pop_at_stop, input int abort_at);
        logic [NBITS-1:0] frame;
        frame = '1;
        frame[0]   = 1'b0;
        frame[8:1] = data;
        if (NPAR == 1) frame[9] = (^data) ^ par_bad;
        frame[NBITS-1] = stop_bit;
        @(posedge clk); #1;
        for (int c = 0; c < NBITS * DIV; c++) begin
            rxd     = frame[c / DIV];
            i_ready = pop_at_stop && (c == STOP_TICK - 1);
            if (pop_at_stop && c == STOP_TICK - 1 && exp_q.size() > 0)
                check("stop_tick_pop_data", 32'(o_data), 32'(exp_q[0]));
            if (c == abort_at) begin
                resetn  = 1'b0;
                rxd     = 1'b1;
                i_ready = 1'b0;
                @(posedge clk); #1;
                resetn = 1'b1;
                model_reset();
                return;
            end
            @(posedge clk); #1;
        end
        i_ready = 1'b0;
        rxd     = 1'b1;
        model_frame(data, stop_bit, par_bad, pop_at_stop);
        repeat (30) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] rb;
        logic       rs;
        bit         rp;
        int         npop;

        // Reset state
        resetn = 1'b0; rxd = 1'b1; i_ready = 1'b0; i_clr_err = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_status("reset");
        check("reset_data",  32'(o_data), 32'h0);
        check("reset_state", 32'(o_state), 32'h0);
        resetn = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // Clean byte
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, -1);
        check("clean_data", 32'(o_data), 32'hA5);
        check_status("clean");
        pop_one("clean");
        check("clean_after_pop_valid", 32'(o_valid), 32'd0);

        // Start glitch followed by a good byte
        rxd = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rxd = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("glitch_state", 32'(o_state), 32'h0);
        check_status("glitch");
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, -1);
        check_status("after_glitch");
        pop_one("after_glitch");

        // Framing error and clear
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, -1);
        check("frame_err_set", 32'(o_frame_err), 32'd1);
        check_status("frame");
        clear_err();
        check("frame_err_clr", 32'(o_frame_err), 32'd0);

        // i_ready while empty is ignored
        i_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        i_ready = 1'b0;
        check_status("empty_pop");

        // Overrun: fifth byte lost
        for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b1, 1'b0, 1'b0, -1);
        check("ovr_level", 32'(o_level), 32'd4);
        check("ovr_flag",  32'(o_overrun), 32'd1);
        for (int b = 1; b <= 4; b++) begin
            check("ovr_order", 32'(o_data), 32'(b));
            pop_one("ovr");
        end
        check_status("ovr_drained");
        clear_err();
        check_status("ovr_clr");

        // Push/pop collision on a full FIFO
        for (int b = 0; b < 4; b++) send_frame(8'($urandom), 1'b1, 1'b0, 1'b0, -1);
        send_frame(8'h77, 1'b1, 1'b0, 1'b1, -1);
        check("coll_ovr",   32'(o_overrun), 32'd0);
        check("coll_level", 32'(o_level), 32'd4);
        check_status("coll");
        for (int b = 0; b < 4; b++) pop_one("coll");
        check_status("coll_drained");

        // Empty FIFO with simultaneous push and pop: the push wins
        send_frame(8'h9E, 1'b1, 1'b0, 1'b1, -1);
        check("empty_coll_level", 32'(o_level), 32'd1);
        check_status("empty_coll");
        pop_one("empty_coll");

`ifdef UART_RX_PARITY_EN
        // Even parity accepted, then rejected
        send_frame(8'h03, 1'b1, 1'b0, 1'b0, -1);
        check("par_ok_data", 32'(o_data), 32'h03);
        check_status("par_ok");
        pop_one("par_ok");
        send_frame(8'h03, 1'b1, 1'b1, 1'b0, -1);
        check("par_bad_ferr", 32'(o_frame_err), 32'd1);
        check_status("par_bad");
        clear_err();
`endif

        // Reset mid-frame during bit 4, with state in the FIFO and a flag raised beforehand
        send_frame(8'h42, 1'b1, 1'b0, 1'b0, -1);
        send_frame(8'h18, 1'b0, 1'b0, 1'b0, -1);
        check_status("pre_reset");
        send_frame(8'hC3, 1'b1, 1'b0, 1'b0, 5 * DIV + 20);
        check_status("mid_reset");
        check("mid_reset_data",  32'(o_data), 32'h0);
        check("mid_reset_state", 32'(o_state), 32'h0);
        repeat (5) @(posedge clk);
        #1;
        rb = 8'($urandom);
        send_frame(rb, 1'b1, 1'b0, 1'b0, -1);
        check("post_reset_data", 32'(o_data), 32'(rb));
        check_status("post_reset");
        pop_one("post_reset");

        // Randomized frames with random pops and occasional bad stop bits
        for (int i = 0; i < 12; i++) begin
            rb = 8'($urandom);
            rs = ($urandom_range(0, 5) != 0);
            rp = ($urandom_range(0, 3) == 0);
            send_frame(rb, rs, 1'b0, rp, -1);
            check_status("rand");
            npop = $urandom_range(0, 2);
            for (int p = 0; p < npop; p++) if (exp_q.size() > 0) pop_one("rand");
            if ($urandom_range(0, 2) == 0) clear_err();
            check_status("rand_post");
        end
        while (exp_q.size() > 0) pop_one("final");
        check_status("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
